handshake_responder: RTL and testbench

HANDSHAKE_RESPONDER -- requirements
Module: handshake_responder

---
 rtl/handshake_responder.sv | 116 +++++++++++
 tb/tb_handshake_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_responder.sv
`default_nettype none
// ============================================================================
//  Module      : handshake_responder
//  Description : Single-outstanding request/acknowledge responder. A rising
//                edge on req in IDLE captures req_data. Zero payloads go
//                straight to ERR. Non-zero payloads wait in WAIT while stall
//                is high, up to MAX_LAT cycles. The block then either returns
//                a one-cycle ack/valid pulse or times out into ERR. ERR is
//                left only through err_clr.
//  Ports       : clk         - clock, rising edge
//                rst         - asynchronous active-high reset
//                req         - request level; a new transaction is its rising edge
//                req_data    - 8-bit payload sampled on acceptance
//                stall       - back-pressure; delays ack while high
//                err_clr     - returns ERR to IDLE
//                ack         - one-cycle acknowledge pulse
//                valid       - qualifies data; high only in the ack cycle
//                data        - captured payload register
//                error_state - high while in ERR
//                counter     - stalled-cycle count; 0 outside WAIT
//  Revision    : 1.0 - initial release
// ============================================================================
module handshake_responder #(
    parameter int MAX_LAT = 10          // legal range 2..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] req_data,
    input  logic       stall,
    input  logic       err_clr,
    output logic       ack,
    output logic       valid,
    output logic [7:0] data,
    output logic       error_state,
    output logic [3:0] counter
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // Last counter value that may still be followed by an ack.
    localparam logic [3:0] C_CNT_LAST = 4'(MAX_LAT - 1);

    state_t     state_q, state_d;
    logic       req_q;
    logic [7:0] data_q, data_d;
    logic [3:0] cnt_q, cnt_d;
    logic       accept;

    // Only a fresh rising edge seen while idle starts a transaction. Edges
    // arriving in other states are dropped, because req_q keeps tracking req.
    assign accept = req & ~req_q & (state_q == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            data_q  <= 8'h00;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = 4'd0;             // counter is zero in every state but WAIT
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    data_d  = req_data;
                    state_d = (req_data == 8'h00) ? S_ERR : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!stall) begin
                    state_d = S_ACK;
                end else if (cnt_q == C_CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                if (err_clr) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only, so nothing is
    // combinationally sensitive to the inputs.
    assign ack         = (state_q == S_ACK);
    assign valid       = (state_q == S_ACK);
    assign error_state = (state_q == S_ERR);
    assign data        = data_q;
    assign counter     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_handshake_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_handshake_responder
//  Description : Directed and randomized bench for handshake_responder.
//                The reference model tracks the transaction as a phase
//                (idle/waiting/acking/errored) plus a stall tally.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_responder;

    localparam int ML = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [7:0] req_data;
    logic       stall;
    logic       err_clr;
    logic       ack;
    logic       valid;
    logic [7:0] data;
    logic       error_state;
    logic [3:0] counter;

    int errors = 0;
    int checks = 0;

    handshake_responder #(.MAX_LAT(ML)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .stall       (stall),
        .err_clr     (err_clr),
        .ack         (ack),
        .valid       (valid),
        .data        (data),
        .error_state (error_state),
        .counter     (counter)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit       m_seen_req;      // req level observed at the previous edge
    bit       m_waiting;       // transaction accepted, not yet answered
    int       m_stalls;        // stalled cycles spent waiting so far
    bit       m_acking;        // this cycle is the acknowledge cycle
    bit       m_errored;       // sitting in the error condition
    bit [7:0] m_payload;
    int       m_acks_expected;
    int       m_acks_seen;

    task automatic model_reset();
        m_seen_req = 0;
        m_waiting  = 0;
        m_stalls   = 0;
        m_acking   = 0;
        m_errored  = 0;
        m_payload  = 8'h00;
    endtask

    task automatic model_edge();
        bit fresh;
        fresh = req && !m_seen_req;
        if (m_errored) begin
            if (err_clr) m_errored = 0;
        end else if (m_acking) begin
            m_acking = 0;
        end else if (m_waiting) begin
            if (!stall) begin
                m_waiting = 0;
                m_acking  = 1;
                m_acks_expected++;
            end else if (m_stalls + 1 >= ML) begin
                m_waiting = 0;          // timed out after ML stalled cycles
                m_errored = 1;
            end else begin
                m_stalls++;
            end
        end else if (fresh) begin
            m_payload = req_data;
            if (req_data == 8'h00) begin
                m_errored = 1;
            end else begin
                m_waiting = 1;
                m_stalls  = 0;
            end
        end
        m_seen_req = req;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ack"},   {7'd0, ack},         {7'd0, m_acking});
        chk({tag, ".valid"}, {7'd0, valid},       {7'd0, m_acking});
        chk({tag, ".err"},   {7'd0, error_state}, {7'd0, m_errored});
        chk({tag, ".cnt"},   {4'd0, counter},     m_waiting ? 8'(m_stalls) : 8'd0);
        chk({tag, ".data"},  data,                m_payload);
        if (valid === 1'b1) chk({tag, ".valid_nonzero"}, {7'd0, (data != 8'h00)}, 8'd1);
    endtask

    // One clock: advance the model at the edge, then compare 1 ns later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        if (ack === 1'b1) m_acks_seen++;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; req_data = 8'h00; stall = 1'b0; err_clr = 1'b0;
        model_reset();
        m_acks_expected = 0;
        m_acks_seen     = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Zero-stall transaction: ack one cycle after the accepting edge.
        req = 1'b1; req_data = 8'h5A;
        step("t1_accept");
        chk("t1_cnt0", {4'd0, counter}, 8'd0);
        req_data = 8'hFF;                 // data must not follow req_data now
        step("t1_ack");
        chk("t1_ack_hi", {7'd0, ack}, 8'd1);
        chk("t1_data", data, 8'h5A);
        req = 1'b0;
        step("t1_idle");
        chk("t1_ack_lo", {7'd0, ack}, 8'd0);

        // Three stalled cycles, then ack; counter runs 0,1,2,3.
        req = 1'b1; req_data = 8'h33; stall = 1'b1;
        step("t2_accept");
        chk("t2_c0", {4'd0, counter}, 8'd0);
        req_data = 8'h00;
        for (int i = 1; i <= 3; i++) begin
            step("t2_stall");
            chk("t2_cnt", {4'd0, counter}, 8'(i));
            chk("t2_hold", data, 8'h33);
        end
        stall = 1'b0;
        step("t2_ack");
        chk("t2_ack_hi", {7'd0, ack}, 8'd1);
        req = 1'b0;
        step("t2_idle");

        // Timeout: stall held high, counter tops out at ML-1, no ack.
        req = 1'b1; req_data = 8'hC3; stall = 1'b1;
        step("t3_accept");
        for (int i = 1; i < ML; i++) step("t3_stall");
        chk("t3_cnt_top", {4'd0, counter}, 8'(ML - 1));
        step("t3_timeout");
        chk("t3_err", {7'd0, error_state}, 8'd1);
        chk("t3_noack", {7'd0, ack}, 8'd0);
        req = 1'b0; stall = 1'b0;
        step("t3_errhold");
        err_clr = 1'b1;
        step("t3_clear");
        chk("t3_cleared", {7'd0, error_state}, 8'd0);
        err_clr = 1'b0;

        // Zero payload goes straight to ERR.
        req = 1'b1; req_data = 8'h00;
        step("t4_zero");
        chk("t4_err", {7'd0, error_state}, 8'd1);
        req = 1'b0;
        step("t4_hold");
        err_clr = 1'b1;
        step("t4_clear");
        err_clr = 1'b0;

        // Extra req edge during WAIT is dropped; req held across ACK.
        req = 1'b1; req_data = 8'h71; stall = 1'b1;
        step("t5_accept");
        req = 1'b0; step("t5_fall");
        req = 1'b1; req_data = 8'h22; step("t5_rise_ignored");
        stall = 1'b0;
        step("t5_ack");
        chk("t5_data", data, 8'h71);
        err_clr = 1'b1;                   // ignored outside ERR
        repeat (4) step("t5_held");
        err_clr = 1'b0;
        req = 1'b0;
        step("t5_low");

        // Asynchronous reset in the middle of WAIT.
        req = 1'b1; req_data = 8'h9C; stall = 1'b1;
        step("t6_accept");
        step("t6_stall");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("t6_async");
        chk("t6_data0", data, 8'h00);
        @(negedge clk);
        rst = 1'b0;                       // req still high: accepted next edge
        step("t6_reaccept");
        chk("t6_redata", data, 8'h9C);
        stall = 1'b0;
        step("t6_ack");
        req = 1'b0;
        step("t6_idle");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) req = ~req;
            req_data = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            stall    = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 19) == 0) stall = 1'b1;
            err_clr  = ($urandom_range(0, 5) == 0);
            step("rand");
        end
        chk("ack_count", 8'(m_acks_seen), 8'(m_acks_expected));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Overall time guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
